// File: rtl/fft_pkg.sv
// Shared constants and types for the MDC FFT stages.
package fft_pkg;

  localparam int FFT_WIDTH = 9;
  localparam int FFT_TW_W  = 9;
  localparam int FFT_DEPTH = 4;

  // Q1.7 twiddles: 128 represents 1.0, so products are rescaled by >>7.
  localparam int TW_SHIFT = 7;

  // W8^k for k = 0..3.
  localparam logic signed [FFT_TW_W-1:0] TW_RE [4] = '{9'sd128, 9'sd91, 9'sd0, -9'sd91};
  localparam logic signed [FFT_TW_W-1:0] TW_IM [4] = '{9'sd0, -9'sd91, -9'sd128, -9'sd91};

  // Commutator routing selected by the top bit of the sample counter.
  typedef enum logic {
    COM_PASS = 1'b0,
    COM_SWAP = 1'b1
  } com_mode_e;

endpackage

// File: rtl/fft_delay_line.sv
// Enable-gated complex shift register; output is the input from DEPTH enables ago.
module fft_delay_line #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 9
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic signed [WIDTH-1:0] in_re,
  input  logic signed [WIDTH-1:0] in_im,
  output logic signed [WIDTH-1:0] out_re,
  output logic signed [WIDTH-1:0] out_im
);

  logic signed [WIDTH-1:0] re_q [DEPTH];
  logic signed [WIDTH-1:0] im_q [DEPTH];
  logic signed [WIDTH-1:0] re_d [DEPTH];
  logic signed [WIDTH-1:0] im_d [DEPTH];

  // Shift one tap per enable, otherwise hold.
  always_comb begin
    re_d = re_q;
    im_d = im_q;
    if (en) begin
      re_d[0] = in_re;
      im_d[0] = in_im;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        re_d[i] = re_q[i-1];
        im_d[i] = im_q[i-1];
      end
    end
  end

  // Tap registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        re_q[i] <= '0;
        im_q[i] <= '0;
      end
    end else begin
      re_q <= re_d;
      im_q <= im_d;
    end
  end

  assign out_re = re_q[DEPTH-1];
  assign out_im = im_q[DEPTH-1];

endmodule

// File: rtl/fft_state3.sv
// Third radix-2 DIF stage of the 32-point MDC FFT: lower delay, commutator,
// upper delay, butterfly and W8 twiddle on the lower branch, registered output.
module fft_state3
  import fft_pkg::*;
#(
  parameter int WIDTH = FFT_WIDTH,
  parameter int TW_W  = FFT_TW_W,
  parameter int DEPTH = FFT_DEPTH
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  input  logic signed [WIDTH-1:0] in_up_re,
  input  logic signed [WIDTH-1:0] in_up_im,
  input  logic signed [WIDTH-1:0] in_l_re,
  input  logic signed [WIDTH-1:0] in_l_im,
  output logic                    out_valid,
  output logic signed [WIDTH-1:0] out_up_re,
  output logic signed [WIDTH-1:0] out_up_im,
  output logic signed [WIDTH-1:0] out_l_re,
  output logic signed [WIDTH-1:0] out_l_im
);

  localparam int PW = WIDTH + 1 + TW_W;
  localparam logic [3:0] FILL_DONE = 4'd8;

  logic [2:0] cnt_q, cnt_d;
  logic [3:0] fill_q, fill_d;
  logic       out_valid_q, out_valid_d;
  logic signed [WIDTH-1:0] out_up_re_q, out_up_im_q, out_l_re_q, out_l_im_q;
  logic signed [WIDTH-1:0] out_up_re_d, out_up_im_d, out_l_re_d, out_l_im_d;

  com_mode_e  mode;
  logic [1:0] tw;

  logic signed [WIDTH-1:0] l_d_re, l_d_im, u_d_re, u_d_im;
  logic signed [WIDTH-1:0] com_up_re, com_up_im, com_l_re, com_l_im;
  logic signed [WIDTH:0]   sum_re, sum_im, diff_re, diff_im;
  logic signed [TW_W-1:0]  w_re, w_im;
  logic signed [PW-1:0]    p_rr, p_ii, p_ri, p_ir, prod_re, prod_im;
  logic                    unused_bits;

  assign mode = com_mode_e'(cnt_q[2]);
  assign tw   = cnt_q[1:0];

  fft_delay_line #(.DEPTH(DEPTH), .WIDTH(WIDTH)) u_l_dly (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (in_valid),
    .in_re  (in_l_re),
    .in_im  (in_l_im),
    .out_re (l_d_re),
    .out_im (l_d_im)
  );

  fft_delay_line #(.DEPTH(DEPTH), .WIDTH(WIDTH)) u_u_dly (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (in_valid),
    .in_re  (com_up_re),
    .in_im  (com_up_im),
    .out_re (u_d_re),
    .out_im (u_d_im)
  );

  // Commutator: route new upper sample or delayed lower sample into the upper delay.
  always_comb begin
    com_up_re = in_up_re;
    com_up_im = in_up_im;
    com_l_re  = l_d_re;
    com_l_im  = l_d_im;
    if (mode == COM_SWAP) begin
      com_up_re = l_d_re;
      com_up_im = l_d_im;
      com_l_re  = in_up_re;
      com_l_im  = in_up_im;
    end
  end

  // Butterfly at WIDTH+1 bits, then full-width complex multiply of diff by W8^tw.
  always_comb begin
    sum_re  = {u_d_re[WIDTH-1], u_d_re} + {com_l_re[WIDTH-1], com_l_re};
    sum_im  = {u_d_im[WIDTH-1], u_d_im} + {com_l_im[WIDTH-1], com_l_im};
    diff_re = {u_d_re[WIDTH-1], u_d_re} - {com_l_re[WIDTH-1], com_l_re};
    diff_im = {u_d_im[WIDTH-1], u_d_im} - {com_l_im[WIDTH-1], com_l_im};
    w_re    = TW_RE[tw];
    w_im    = TW_IM[tw];
    p_rr    = diff_re * w_re;
    p_ii    = diff_im * w_im;
    p_ri    = diff_re * w_im;
    p_ir    = diff_im * w_re;
    prod_re = p_rr - p_ii;
    prod_im = p_ri + p_ir;
  end

  // Next-state: counters and output registers advance only on accept.
  always_comb begin
    cnt_d       = cnt_q;
    fill_d      = fill_q;
    out_valid_d = 1'b0;
    out_up_re_d = out_up_re_q;
    out_up_im_d = out_up_im_q;
    out_l_re_d  = out_l_re_q;
    out_l_im_d  = out_l_im_q;
    if (in_valid) begin
      cnt_d       = cnt_q + 3'd1;
      fill_d      = (fill_q == FILL_DONE) ? fill_q : fill_q + 4'd1;
      out_valid_d = (fill_q == FILL_DONE);
      out_up_re_d = sum_re[WIDTH-1:0];
      out_up_im_d = sum_im[WIDTH-1:0];
      out_l_re_d  = prod_re[WIDTH+TW_SHIFT-1:TW_SHIFT];
      out_l_im_d  = prod_im[WIDTH+TW_SHIFT-1:TW_SHIFT];
    end
  end

  // State and output registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      fill_q      <= '0;
      out_valid_q <= 1'b0;
      out_up_re_q <= '0;
      out_up_im_q <= '0;
      out_l_re_q  <= '0;
      out_l_im_q  <= '0;
    end else begin
      cnt_q       <= cnt_d;
      fill_q      <= fill_d;
      out_valid_q <= out_valid_d;
      out_up_re_q <= out_up_re_d;
      out_up_im_q <= out_up_im_d;
      out_l_re_q  <= out_l_re_d;
      out_l_im_q  <= out_l_im_d;
    end
  end

  // Discarded bits: butterfly carry and product bits outside the output window.
  assign unused_bits = ^{sum_re[WIDTH], sum_im[WIDTH],
                         prod_re[PW-1:WIDTH+TW_SHIFT], prod_re[TW_SHIFT-1:0],
                         prod_im[PW-1:WIDTH+TW_SHIFT], prod_im[TW_SHIFT-1:0]};

  assign out_valid = out_valid_q;
  assign out_up_re = out_up_re_q;
  assign out_up_im = out_up_im_q;
  assign out_l_re  = out_l_re_q;
  assign out_l_im  = out_l_im_q;

endmodule

// File: tb/tb_fft_state3.sv
// Scoreboard bench for fft_state3: a history-indexed model pushes the expected
// output for every driven cycle; each scenario pops and compares after the edge.
module tb_fft_state3;

  logic clk = 1'b0;
  logic rst_n;
  logic in_valid;
  logic signed [8:0] in_up_re, in_up_im, in_l_re, in_l_im;
  logic out_valid;
  logic signed [8:0] out_up_re, out_up_im, out_l_re, out_l_im;

  fft_state3 #(.WIDTH(9), .TW_W(9), .DEPTH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_up_re  (in_up_re),
    .in_up_im  (in_up_im),
    .in_l_re   (in_l_re),
    .in_l_im   (in_l_im),
    .out_valid (out_valid),
    .out_up_re (out_up_re),
    .out_up_im (out_up_im),
    .out_l_re  (out_l_re),
    .out_l_im  (out_l_im)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic              v;
    logic signed [8:0] ur, ui, lr, li;
  } exp_t;

  exp_t sb[$];
  exp_t last;
  int   vectors = 0;
  int   miscompares = 0;

  // Model state: per-accept history of lower inputs and upper-delay inputs.
  int n_acc;
  int hl_re[$], hl_im[$], hc_re[$], hc_im[$];
  int WR[4] = '{128, 91, 0, -91};
  int WI[4] = '{0, -91, -128, -91};

  task automatic model_reset();
    n_acc = 0;
    hl_re.delete(); hl_im.delete(); hc_re.delete(); hc_im.delete();
    sb.delete();
    last = '{v: 1'b0, ur: '0, ui: '0, lr: '0, li: '0};
  endtask

  // Drive one cycle (inputs set at posedge+1), push the expected result, advance to posedge+1.
  task automatic drive(input logic v, input int ur, input int ui, input int lr, input int li);
    exp_t e;
    int ld_re, ld_im, ud_re, ud_im, cu_re, cu_im, cl_re, cl_im;
    int d_re, d_im, p_re, p_im, t;
    in_valid = v;
    in_up_re = 9'(ur); in_up_im = 9'(ui);
    in_l_re  = 9'(lr); in_l_im  = 9'(li);
    if (v) begin
      ld_re = (n_acc >= 4) ? hl_re[n_acc-4] : 0;
      ld_im = (n_acc >= 4) ? hl_im[n_acc-4] : 0;
      ud_re = (n_acc >= 4) ? hc_re[n_acc-4] : 0;
      ud_im = (n_acc >= 4) ? hc_im[n_acc-4] : 0;
      if ((n_acc % 8) < 4) begin
        cu_re = int'(in_up_re); cu_im = int'(in_up_im); cl_re = ld_re; cl_im = ld_im;
      end else begin
        cu_re = ld_re; cu_im = ld_im; cl_re = int'(in_up_re); cl_im = int'(in_up_im);
      end
      hl_re.push_back(int'(in_l_re)); hl_im.push_back(int'(in_l_im));
      hc_re.push_back(cu_re); hc_im.push_back(cu_im);
      t    = n_acc % 4;
      d_re = ud_re - cl_re;
      d_im = ud_im - cl_im;
      p_re = d_re * WR[t] - d_im * WI[t];
      p_im = d_re * WI[t] + d_im * WR[t];
      e.v  = (n_acc >= 8);
      e.ur = 9'(ud_re + cl_re);
      e.ui = 9'(ud_im + cl_im);
      e.lr = 9'(p_re >>> 7);
      e.li = 9'(p_im >>> 7);
      n_acc++;
    end else begin
      e = last;
      e.v = 1'b0;
    end
    last = e;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    in_valid = 1'b0;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  function automatic int rnd9();
    return int'($urandom_range(511)) - 256;
  endfunction

  task automatic test_reset();
    exp_t e;
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_up_re = 9'(rnd9()); in_up_im = 9'(rnd9());
      in_l_re  = 9'(rnd9()); in_l_im  = 9'(rnd9());
      @(posedge clk);
      #1;
      vectors++;
      if ({out_valid, out_up_re, out_up_im, out_l_re, out_l_im} !== 37'd0) begin
        miscompares++;
        $display("FAIL reset_hold cyc=%0d got v=%0b up=(%0d,%0d) l=(%0d,%0d) want all 0",
                 i, out_valid, out_up_re, out_up_im, out_l_re, out_l_im);
      end
    end
    rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 9; i++) begin
      drive(1'b1, 0, 0, 0, 0);
      e = sb.pop_front();
      vectors++;
      if ({out_valid, out_up_re, out_up_im, out_l_re, out_l_im} !== {e.v, e.ur, e.ui, e.lr, e.li}) begin
        miscompares++;
        $display("FAIL reset_fill acc=%0d got v=%0b up=(%0d,%0d) l=(%0d,%0d) want v=%0b up=(%0d,%0d) l=(%0d,%0d)",
                 i, out_valid, out_up_re, out_up_im, out_l_re, out_l_im, e.v, e.ur, e.ui, e.lr, e.li);
      end
      vectors++;
      if (out_valid !== (i == 8)) begin
        miscompares++;
        $display("FAIL reset_valid acc=%0d got %0b want %0b", i, out_valid, (i == 8));
      end
    end
  endtask

  task automatic test_constant();
    exp_t e;
    apply_reset();
    for (int i = 0; i < 24; i++) begin
      drive(1'b1, 10, 0, 10, 0);
      e = sb.pop_front();
      vectors++;
      if ({out_valid, out_up_re, out_up_im, out_l_re, out_l_im} !== {e.v, e.ur, e.ui, e.lr, e.li}) begin
        miscompares++;
        $display("FAIL constant acc=%0d got v=%0b up=(%0d,%0d) l=(%0d,%0d) want v=%0b up=(%0d,%0d) l=(%0d,%0d)",
                 i, out_valid, out_up_re, out_up_im, out_l_re, out_l_im, e.v, e.ur, e.ui, e.lr, e.li);
      end
      if (i >= 8) begin
        vectors++;
        if ({out_valid, out_up_re, out_up_im, out_l_re, out_l_im} !== {1'b1, 9'sd20, 9'sd0, 9'sd0, 9'sd0}) begin
          miscompares++;
          $display("FAIL constant_value acc=%0d got v=%0b up=(%0d,%0d) l=(%0d,%0d) want v=1 up=(20,0) l=(0,0)",
                   i, out_valid, out_up_re, out_up_im, out_l_re, out_l_im);
        end
      end
    end
  endtask

  task automatic test_impulse();
    exp_t e;
    int LR[8] = '{64, 45, 0, -46, 0, 0, 0, 0};
    int LI[8] = '{0, -46, -64, -46, 0, 0, 0, 0};
    int up;
    apply_reset();
    for (int i = 0; i < 32; i++) begin
      drive(1'b1, 0, 0, ((i % 8) < 4) ? 64 : 0, 0);
      e = sb.pop_front();
      vectors++;
      if ({out_valid, out_up_re, out_up_im, out_l_re, out_l_im} !== {e.v, e.ur, e.ui, e.lr, e.li}) begin
        miscompares++;
        $display("FAIL impulse acc=%0d got v=%0b up=(%0d,%0d) l=(%0d,%0d) want v=%0b up=(%0d,%0d) l=(%0d,%0d)",
                 i, out_valid, out_up_re, out_up_im, out_l_re, out_l_im, e.v, e.ur, e.ui, e.lr, e.li);
      end
      if (i >= 8) begin
        up = ((i % 8) < 4) ? 64 : 0;
        vectors++;
        if ({out_up_re, out_up_im, out_l_re, out_l_im} !== {9'(up), 9'sd0, 9'(LR[i%8]), 9'(LI[i%8])}) begin
          miscompares++;
          $display("FAIL impulse_value cnt=%0d got up=(%0d,%0d) l=(%0d,%0d) want up=(%0d,0) l=(%0d,%0d)",
                   i % 8, out_up_re, out_up_im, out_l_re, out_l_im, up, LR[i%8], LI[i%8]);
        end
      end
    end
  endtask

  task automatic test_stall();
    exp_t e;
    apply_reset();
    for (int i = 0; i < 30; i++) begin
      if (i >= 12 && i < 15) drive(1'b0, 10, 0, 10, 0);
      else drive(1'b1, 10, 0, 10, 0);
      e = sb.pop_front();
      vectors++;
      if ({out_valid, out_up_re, out_up_im, out_l_re, out_l_im} !== {e.v, e.ur, e.ui, e.lr, e.li}) begin
        miscompares++;
        $display("FAIL stall cyc=%0d got v=%0b up=(%0d,%0d) l=(%0d,%0d) want v=%0b up=(%0d,%0d) l=(%0d,%0d)",
                 i, out_valid, out_up_re, out_up_im, out_l_re, out_l_im, e.v, e.ur, e.ui, e.lr, e.li);
      end
      vectors++;
      if (out_valid !== (i >= 8 && !(i >= 12 && i < 15))) begin
        miscompares++;
        $display("FAIL stall_valid cyc=%0d got %0b want %0b", i, out_valid, (i >= 8 && !(i >= 12 && i < 15)));
      end
    end
  endtask

  task automatic test_overflow();
    exp_t e;
    logic signed [8:0] want_re, want_im;
    int s;
    s = 400;
    want_re = 9'(s);
    want_im = 9'(-s);
    apply_reset();
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 200, -200, 200, -200);
      e = sb.pop_front();
      vectors++;
      if ({out_valid, out_up_re, out_up_im, out_l_re, out_l_im} !== {e.v, e.ur, e.ui, e.lr, e.li}) begin
        miscompares++;
        $display("FAIL overflow acc=%0d got v=%0b up=(%0d,%0d) l=(%0d,%0d) want v=%0b up=(%0d,%0d) l=(%0d,%0d)",
                 i, out_valid, out_up_re, out_up_im, out_l_re, out_l_im, e.v, e.ur, e.ui, e.lr, e.li);
      end
      if (i >= 8) begin
        vectors++;
        if ({out_up_re, out_up_im, out_l_re, out_l_im} !== {want_re, want_im, 9'sd0, 9'sd0}) begin
          miscompares++;
          $display("FAIL overflow_wrap acc=%0d got up=(%0d,%0d) l=(%0d,%0d) want up=(%0d,%0d) l=(0,0)",
                   i, out_up_re, out_up_im, out_l_re, out_l_im, want_re, want_im);
        end
      end
    end
  endtask

  task automatic test_reset_midframe();
    exp_t e;
    apply_reset();
    for (int i = 0; i < 13; i++) begin
      drive(1'b1, rnd9(), rnd9(), rnd9(), rnd9());
      e = sb.pop_front();
      vectors++;
      if ({out_valid, out_up_re, out_up_im, out_l_re, out_l_im} !== {e.v, e.ur, e.ui, e.lr, e.li}) begin
        miscompares++;
        $display("FAIL midreset_pre acc=%0d got v=%0b up=(%0d,%0d) l=(%0d,%0d) want v=%0b up=(%0d,%0d) l=(%0d,%0d)",
                 i, out_valid, out_up_re, out_up_im, out_l_re, out_l_im, e.v, e.ur, e.ui, e.lr, e.li);
      end
    end
    #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({out_valid, out_up_re, out_up_im, out_l_re, out_l_im} !== 37'd0) begin
      miscompares++;
      $display("FAIL midreset_async got v=%0b up=(%0d,%0d) l=(%0d,%0d) want all 0",
               out_valid, out_up_re, out_up_im, out_l_re, out_l_im);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, rnd9(), rnd9(), rnd9(), rnd9());
      e = sb.pop_front();
      vectors++;
      if ({out_valid, out_up_re, out_up_im, out_l_re, out_l_im} !== {e.v, e.ur, e.ui, e.lr, e.li}) begin
        miscompares++;
        $display("FAIL midreset_post acc=%0d got v=%0b up=(%0d,%0d) l=(%0d,%0d) want v=%0b up=(%0d,%0d) l=(%0d,%0d)",
                 i, out_valid, out_up_re, out_up_im, out_l_re, out_l_im, e.v, e.ur, e.ui, e.lr, e.li);
      end
      vectors++;
      if (out_valid !== (i >= 8)) begin
        miscompares++;
        $display("FAIL midreset_valid acc=%0d got %0b want %0b", i, out_valid, (i >= 8));
      end
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    apply_reset();
    for (int i = 0; i < 80; i++) begin
      drive($urandom_range(3) != 0, rnd9(), rnd9(), rnd9(), rnd9());
      e = sb.pop_front();
      vectors++;
      if ({out_valid, out_up_re, out_up_im, out_l_re, out_l_im} !== {e.v, e.ur, e.ui, e.lr, e.li}) begin
        miscompares++;
        $display("FAIL random cyc=%0d got v=%0b up=(%0d,%0d) l=(%0d,%0d) want v=%0b up=(%0d,%0d) l=(%0d,%0d)",
                 i, out_valid, out_up_re, out_up_im, out_l_re, out_l_im, e.v, e.ur, e.ui, e.lr, e.li);
      end
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_up_re = '0; in_up_im = '0; in_l_re = '0; in_l_im = '0;
    model_reset();
    #1;
    test_reset();
    test_constant();
    test_impulse();
    test_stall();
    test_overflow();
    test_reset_midframe();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

endmodule
